mem_rr_arbiter: RTL and testbench
=================================

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, requester count; legal values 1..16.
REQ-004 SHALL have parameter WRITE_ENABLE, default 1; when 0, write requests are ignored and write outputs are held 0.
REQ-005 SHALL have clk, input, 1, clock; all logic rising-edge.
REQ-006 SHALL have reset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have consumer_read_valid, input, NUM_CONSUMERS, per-consumer read request.
REQ-008 SHALL have consumer_read_address, input, NUM_CONSUMERS*ADDR_BITS, packed read addresses; consumer j occupies slice j.
REQ-009 SHALL have consumer_read_ready, output, NUM_CONSUMERS, per-consumer read completion.
REQ-010 SHALL have consumer_read_data, output, NUM_CONSUMERS*DATA_BITS, packed read data.
REQ-011 SHALL have consumer_write_valid, input, NUM_CONSUMERS, and consumer_write_address, input, NUM_CONSUMERS*ADDR_BITS.
REQ-012 SHALL have consumer_write_data, input, NUM_CONSUMERS*DATA_BITS, and consumer_write_ready, output, NUM_CONSUMERS.
REQ-013 SHALL have mem_read_valid, output, 1; mem_read_address, output, ADDR_BITS; mem_read_ready, input, 1; mem_read_data, input, DATA_BITS.
REQ-014 SHALL have mem_write_valid, output, 1; mem_write_address, output, ADDR_BITS; mem_write_data, output, DATA_BITS; mem_write_ready, input, 1.
REQ-015 SHALL have busy, output, 1, high whenever state is not IDLE.
REQ-016 SHALL have grant_id, output, clog2(NUM_CONSUMERS) (min 1), index of the consumer currently served.

Function
REQ-017 SHALL implement states IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY; all outputs registered.
REQ-018 IDLE: SHALL scan consumers from rr_ptr upward modulo NUM_CONSUMERS and grant the first j with read_valid[j] or (WRITE_ENABLE and write_valid[j]).
REQ-019 Same consumer with read and write valid: read SHALL win; the write is served on a later grant.
REQ-020 On grant SHALL register grant_id<=j, rr_ptr<=(j+1) mod NUM_CONSUMERS, and assert mem_read_valid with the address (or mem_write_valid with address and data) on the next cycle; go to READ_WAIT/WRITE_WAIT.
REQ-021 mem_*_address and mem_write_data SHALL be stable while the matching mem_*_valid is high.
REQ-022 READ_WAIT: on mem_read_ready SHALL drop mem_read_valid, set consumer_read_ready[grant_id]=1, latch mem_read_data into slice grant_id, go to READ_RELAY.
REQ-023 WRITE_WAIT: on mem_write_ready SHALL drop mem_write_valid, set consumer_write_ready[grant_id]=1, go to WRITE_RELAY.
REQ-024 *_RELAY: SHALL hold ready until the consumer's matching valid is low, then clear ready and return to IDLE in the same edge.
REQ-025 A consumer deasserting valid during *_WAIT SHALL NOT abort the memory transaction; ready then pulses exactly one cycle.
REQ-026 consumer_read_data slices SHALL hold their value until overwritten by that consumer's next read completion.
REQ-027 Minimum latency: request sampled at edge N, mem valid high after N+1, with mem ready at that edge consumer ready high after N+2.
REQ-028 IDLE SHALL consume at least one cycle between transactions; no new grant from a RELAY state.
REQ-029 NUM_CONSUMERS=1: rr_ptr SHALL stay 0 and grant_id SHALL be 0.
REQ-030 Ready inputs from memory outside the matching WAIT state SHALL be ignored.

Reset
REQ-031 On reset SHALL force state IDLE, rr_ptr 0, grant_id 0, busy 0, all valid/ready outputs 0, all address/data outputs 0.
REQ-032 Reset mid-transaction SHALL abandon it: mem valid low the cycle after reset, no consumer ready issued.

Verification
REQ-033 Single read: consumer 2 reads 0x10, memory returns 0x1234 one cycle after valid -> ready[2]=1 two cycles after request, data slice 2=0x1234, ready clears one cycle after valid drops.
REQ-034 Fairness: all 4 consumers hold read_valid continuously -> grant order 0,1,2,3,0 with rr_ptr wrap.
REQ-035 Read/write collision: consumer 1 asserts both -> read granted first, write (addr 0x20, data 0xBEEF) granted on a later turn with mem_write_data=0xBEEF.
REQ-036 WRITE_ENABLE=0: write_valid on consumer 0 -> mem_write_valid never asserts, write_ready stays 0, busy stays 0.
REQ-037 Reset during READ_WAIT -> next cycle all outputs 0, state IDLE; a later request is granted starting from consumer 0.
REQ-038 Early valid drop: consumer drops read_valid in READ_WAIT -> memory read completes, read_ready pulses exactly one cycle.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares one memory read/write port among NUM_CONSUMERS
// requesters. One transaction is in flight at a time, and every output is registered.
module mem_rr_arbiter #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned WRITE_ENABLE  = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
    output logic                                mem_read_valid,
    output logic [ADDR_BITS-1:0]                mem_read_address,
    input  logic                                mem_read_ready,
    input  logic [DATA_BITS-1:0]                mem_read_data,
    output logic                                mem_write_valid,
    output logic [ADDR_BITS-1:0]                mem_write_address,
    output logic [DATA_BITS-1:0]                mem_write_data,
    input  logic                                mem_write_ready,
    output logic                                busy,
    output logic [(NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1)-1:0] grant_id
);

    localparam int unsigned ID_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    localparam logic [2:0] StIdle       = 3'd0;
    localparam logic [2:0] StReadWait   = 3'd1;
    localparam logic [2:0] StWriteWait  = 3'd2;
    localparam logic [2:0] StReadRelay  = 3'd3;
    localparam logic [2:0] StWriteRelay = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [ID_BITS-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_BITS-1:0]       grant_q, grant_d;
    logic                     busy_q, busy_d;
    logic                     mem_rd_valid_q, mem_rd_valid_d;
    logic [ADDR_BITS-1:0]     mem_rd_addr_q, mem_rd_addr_d;
    logic                     mem_wr_valid_q, mem_wr_valid_d;
    logic [ADDR_BITS-1:0]     mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_BITS-1:0]     mem_wr_data_q, mem_wr_data_d;
    logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0] wr_ready_q, wr_ready_d;
    logic [DATA_BITS-1:0]     rd_data_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     rd_data_d [NUM_CONSUMERS];

    logic [ADDR_BITS-1:0]     rd_addr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]     wr_addr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     wr_data [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] wr_req;
    logic [NUM_CONSUMERS-1:0] any_req;

    // With writes disabled, write requests simply never become visible to arbitration.
    assign wr_req  = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign any_req = consumer_read_valid | wr_req;

    for (genvar j = 0; j < NUM_CONSUMERS; j++) begin : g_slice
        assign rd_addr[j] = consumer_read_address[j*ADDR_BITS +: ADDR_BITS];
        assign wr_addr[j] = consumer_write_address[j*ADDR_BITS +: ADDR_BITS];
        assign wr_data[j] = consumer_write_data[j*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[j*DATA_BITS +: DATA_BITS] = rd_data_q[j];
    end

    logic [ID_BITS-1:0] pick;
    logic [ID_BITS-1:0] cand;
    logic               found;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick  = rr_ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            cand = ID_BITS'((32'(rr_ptr_q) + k) % NUM_CONSUMERS);
            if (!found && any_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        mem_rd_valid_d = mem_rd_valid_q;
        mem_rd_addr_d  = mem_rd_addr_q;
        mem_wr_valid_d = mem_wr_valid_q;
        mem_wr_addr_d  = mem_wr_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        rd_ready_d     = rd_ready_q;
        wr_ready_d     = wr_ready_q;
        rd_data_d      = rd_data_q;

        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d  = pick;
                    rr_ptr_d = ID_BITS'((32'(pick) + 32'd1) % NUM_CONSUMERS);
                    // A read beats a write from the same consumer.
                    if (consumer_read_valid[pick]) begin
                        mem_rd_valid_d = 1'b1;
                        mem_rd_addr_d  = rd_addr[pick];
                        state_d        = StReadWait;
                    end else begin
                        mem_wr_valid_d = 1'b1;
                        mem_wr_addr_d  = wr_addr[pick];
                        mem_wr_data_d  = wr_data[pick];
                        state_d        = StWriteWait;
                    end
                end
            end
            StReadWait: begin
                if (mem_read_ready) begin
                    mem_rd_valid_d      = 1'b0;
                    rd_ready_d[grant_q] = 1'b1;
                    rd_data_d[grant_q]  = mem_read_data;
                    state_d             = StReadRelay;
                end
            end
            StWriteWait: begin
                if (mem_write_ready) begin
                    mem_wr_valid_d      = 1'b0;
                    wr_ready_d[grant_q] = 1'b1;
                    state_d             = StWriteRelay;
                end
            end
            StReadRelay: begin
                if (!consumer_read_valid[grant_q]) begin
                    rd_ready_d[grant_q] = 1'b0;
                    state_d             = StIdle;
                end
            end
            StWriteRelay: begin
                if (!wr_req[grant_q]) begin
                    wr_ready_d[grant_q] = 1'b0;
                    state_d             = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            busy_q         <= 1'b0;
            mem_rd_valid_q <= 1'b0;
            mem_rd_addr_q  <= '0;
            mem_wr_valid_q <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            rd_ready_q     <= '0;
            wr_ready_q     <= '0;
            for (int j = 0; j < NUM_CONSUMERS; j++) begin
                rd_data_q[j] <= '0;
            end
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            busy_q         <= busy_d;
            mem_rd_valid_q <= mem_rd_valid_d;
            mem_rd_addr_q  <= mem_rd_addr_d;
            mem_wr_valid_q <= mem_wr_valid_d;
            mem_wr_addr_q  <= mem_wr_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            rd_ready_q     <= rd_ready_d;
            wr_ready_q     <= wr_ready_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_write_ready = wr_ready_q;
    assign mem_read_valid       = mem_rd_valid_q;
    assign mem_read_address     = mem_rd_addr_q;
    assign mem_write_valid      = mem_wr_valid_q;
    assign mem_write_address    = mem_wr_addr_q;
    assign mem_write_data       = mem_wr_data_q;
    assign busy                 = busy_q;
    assign grant_id             = grant_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed vector table, hand-written corner sequences and
// a randomized run checked against a transaction-level reference model.
module tb_mem_rr_arbiter;

    localparam int NC = 4;
    localparam int AB = 8;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NC-1:0]    rv, wv;
    logic [NC*AB-1:0] raddr, waddr;
    logic [NC*DB-1:0] wdata;
    logic             mrr, mwr;
    logic [DB-1:0]    mrd;

    logic [NC-1:0]    rrdy, wrdy;
    logic [NC*DB-1:0] rdata;
    logic             mrv, mwv, busy;
    logic [AB-1:0]    mra, mwa;
    logic [DB-1:0]    mwd;
    logic [1:0]       gid;

    logic [NC-1:0]    n_rrdy, n_wrdy;
    logic [NC*DB-1:0] n_rdata;
    logic             n_mrv, n_mwv, n_busy;
    logic [AB-1:0]    n_mra, n_mwa;
    logic [DB-1:0]    n_mwd;
    logic [1:0]       n_gid;

    mem_rr_arbiter dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(raddr),
        .consumer_read_ready(rrdy), .consumer_read_data(rdata),
        .consumer_write_valid(wv), .consumer_write_address(waddr),
        .consumer_write_data(wdata), .consumer_write_ready(wrdy),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
        .mem_write_ready(mwr), .busy(busy), .grant_id(gid)
    );

    mem_rr_arbiter #(.WRITE_ENABLE(0)) dut_nw (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(raddr),
        .consumer_read_ready(n_rrdy), .consumer_read_data(n_rdata),
        .consumer_write_valid(wv), .consumer_write_address(waddr),
        .consumer_write_data(wdata), .consumer_write_ready(n_wrdy),
        .mem_read_valid(n_mrv), .mem_read_address(n_mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(n_mwv), .mem_write_address(n_mwa), .mem_write_data(n_mwd),
        .mem_write_ready(mwr), .busy(n_busy), .grant_id(n_gid)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          cons;
        logic [7:0]  addr;
        logic [15:0] data;
    } rd_vec_t;

    rd_vec_t     vecs [4];
    logic [15:0] exp_slice [NC];
    logic [15:0] mem_model [256];

    // Reference model: who owns the port, what they asked for, and whether memory answered.
    int          m_ptr, m_owner, m_grant;
    bit          m_write, m_done;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_slice [NC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for the arbiter at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC*DB-1:0] pack(input logic [15:0] s [NC]);
        logic [NC*DB-1:0] v;
        for (int j = 0; j < NC; j++) v[j*DB +: DB] = s[j];
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
        mrr = 1'b0; mwr = 1'b0; mrd = '0;
        step();
        step();
        reset = 1'b0;
        for (int j = 0; j < NC; j++) begin
            exp_slice[j] = '0;
            m_slice[j]   = '0;
        end
        m_ptr = 0; m_owner = -1; m_grant = 0; m_write = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit found;
        found = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < NC; k++) begin
                int j;
                j = (m_ptr + k) % NC;
                if (!found && (rv[j] || wv[j])) begin
                    found   = 1;
                    m_owner = j;
                    m_grant = j;
                    m_write = !rv[j];
                    m_done  = 0;
                    m_ptr   = (j + 1) % NC;
                    m_addr  = m_write ? waddr[j*AB +: AB] : raddr[j*AB +: AB];
                    m_wdata = wdata[j*DB +: DB];
                end
            end
        end else if (!m_done) begin
            if (!m_write && mrr) begin
                m_done = 1;
                m_slice[m_owner] = mem_model[m_addr];
            end else if (m_write && mwr) begin
                m_done = 1;
                mem_model[m_addr] = m_wdata;
            end
        end else if (!(m_write ? wv[m_owner] : rv[m_owner])) begin
            m_owner = -1;
        end
    endtask

    task automatic chk_model();
        logic          e_mrv, e_mwv;
        logic [NC-1:0] e_rr, e_wr;
        e_mrv = (m_owner >= 0) && !m_done && !m_write;
        e_mwv = (m_owner >= 0) && !m_done && m_write;
        e_rr  = ((m_owner >= 0) && m_done && !m_write) ? (NC'(1) << m_owner) : '0;
        e_wr  = ((m_owner >= 0) && m_done && m_write) ? (NC'(1) << m_owner) : '0;
        chk("rnd_busy", busy, m_owner >= 0);
        chk("rnd_mem_read_valid", mrv, e_mrv);
        chk("rnd_mem_write_valid", mwv, e_mwv);
        chk("rnd_read_ready", rrdy, e_rr);
        chk("rnd_write_ready", wrdy, e_wr);
        chk("rnd_grant_id", gid, m_grant);
        chk("rnd_read_data", rdata, pack(m_slice));
        if (e_mrv) chk("rnd_read_addr", mra, m_addr);
        if (e_mwv) begin
            chk("rnd_write_addr", mwa, m_addr);
            chk("rnd_write_data", mwd, m_wdata);
        end
        chk("rnd_nw_write_valid", n_mwv, 0);
        chk("rnd_nw_write_ready", n_wrdy, 0);
    endtask

    task automatic drive_random();
        for (int j = 0; j < NC; j++) begin
            if (rv[j]) begin
                if (rrdy[j] || $urandom_range(0, 19) == 0) rv[j] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                rv[j] = 1'b1;
                raddr[j*AB +: AB] = 8'($urandom_range(0, 15));
            end
            if (wv[j]) begin
                if (wrdy[j] || $urandom_range(0, 19) == 0) wv[j] = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                wv[j] = 1'b1;
                waddr[j*AB +: AB] = 8'($urandom_range(0, 15));
                wdata[j*DB +: DB] = 16'($urandom);
            end
        end
        mrr = ($urandom_range(0, 2) == 0);
        mwr = ($urandom_range(0, 2) == 0);
        mrd = mrv ? mem_model[mra] : 16'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  c;
        bit  got;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
        vecs[0] = '{cons: 2, addr: 8'h10, data: 16'h1234};
        vecs[1] = '{cons: 0, addr: 8'hFF, data: 16'hA5A5};
        vecs[2] = '{cons: 3, addr: 8'h00, data: 16'hFFFF};
        vecs[3] = '{cons: 1, addr: 8'h7E, data: 16'h0001};

        // Reset state.
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_valids", {mrv, mwv}, 0);
        chk("rst_readies", {rrdy, wrdy}, 0);
        chk("rst_grant_id", gid, 0);
        chk("rst_addr_data", {mra, mwa, mwd}, 0);
        chk("rst_read_data", rdata, 0);

        // Single reads from the vector table.
        for (int i = 0; i < 4; i++) begin
            c = vecs[i].cons;
            rv[c] = 1'b1;
            raddr[c*AB +: AB] = vecs[i].addr;
            step();
            chk("vec_grant_valid", mrv, 1);
            chk("vec_grant_addr", mra, vecs[i].addr);
            chk("vec_grant_id", gid, c);
            chk("vec_busy", busy, 1);
            step();
            chk("vec_wait_hold", {mrv, rrdy}, {1'b1, 4'b0});
            chk("vec_addr_stable", mra, vecs[i].addr);
            mrr = 1'b1;
            mrd = vecs[i].data;
            step();
            mrr = 1'b0;
            mrd = 16'hDEAD;
            exp_slice[c] = vecs[i].data;
            chk("vec_ready", rrdy, NC'(1) << c);
            chk("vec_valid_drop", mrv, 0);
            chk("vec_data", rdata, pack(exp_slice));
            step();
            chk("vec_ready_hold", rrdy, NC'(1) << c);
            rv[c] = 1'b0;
            step();
            chk("vec_ready_clear", rrdy, 0);
            chk("vec_idle", busy, 0);
            mrr = 1'b1;
            mwr = 1'b1;
            step();
            mrr = 1'b0;
            mwr = 1'b0;
            chk("vec_stray_ready", {rrdy, wrdy, mrv, mwv}, 0);
            chk("vec_data_kept", rdata, pack(exp_slice));
        end

        // Fairness: every consumer keeps re-requesting.
        do_reset();
        rv = '1;
        for (int j = 0; j < NC; j++) raddr[j*AB +: AB] = 8'(j * 4);
        for (int g = 0; g < 5; g++) begin
            got = 0;
            for (int t = 0; t < 10 && !got; t++) begin
                step();
                if (mrv) got = 1;
            end
            if (!got) begin
                timeout_fail("fair_wait");
            end else begin
                chk("fair_grant", gid, g % NC);
                chk("fair_addr", mra, (g % NC) * 4);
            end
            mrr = 1'b1;
            mrd = 16'(g);
            step();
            mrr = 1'b0;
            chk("fair_ready", rrdy, NC'(1) << (g % NC));
            rv[g % NC] = 1'b0;
            step();
            rv[g % NC] = 1'b1;
        end
        rv = '0;

        // Read/write collision on consumer 1.
        do_reset();
        rv[1] = 1'b1; raddr[1*AB +: AB] = 8'h30;
        wv[1] = 1'b1; waddr[1*AB +: AB] = 8'h20; wdata[1*DB +: DB] = 16'hBEEF;
        step();
        chk("col_read_first", {mrv, mwv}, 2'b10);
        chk("col_grant_id", gid, 1);
        mrr = 1'b1; mrd = 16'h5555;
        step();
        mrr = 1'b0;
        chk("col_read_ready", {rrdy, wrdy}, {4'b0010, 4'b0000});
        rv[1] = 1'b0;
        step();
        chk("col_idle", busy, 0);
        step();
        chk("col_write_grant", {mrv, mwv}, 2'b01);
        chk("col_write_id", gid, 1);
        chk("col_write_addr", mwa, 8'h20);
        chk("col_write_data", mwd, 16'hBEEF);
        step();
        chk("col_write_stable", {mwv, mwd}, {1'b1, 16'hBEEF});
        mwr = 1'b1;
        step();
        mwr = 1'b0;
        chk("col_write_ready", {wrdy, mwv}, {4'b0010, 1'b0});
        wv[1] = 1'b0;
        step();
        chk("col_write_done", {wrdy, busy}, 0);

        // Writes disabled.
        do_reset();
        wv[0] = 1'b1; waddr[0 +: AB] = 8'h55; wdata[0 +: DB] = 16'h1111;
        for (int t = 0; t < 6; t++) begin
            mwr = t[0];
            step();
            chk("nw_idle", {n_mwv, n_wrdy, n_busy}, 0);
        end
        wv = '0; mwr = 1'b0;

        // Reset during a read wait.
        do_reset();
        rv[3] = 1'b1;
        step();
        mrr = 1'b1; mrd = 16'h7777;
        step();
        mrr = 1'b0; rv[3] = 1'b0;
        step();
        rv[2] = 1'b1; raddr[2*AB +: AB] = 8'h44;
        step();
        step();
        chk("rstw_pre_grant", {mrv, gid}, {1'b1, 2'd2});
        reset = 1'b1; mrr = 1'b1; mrd = 16'h9999;
        step();
        reset = 1'b0; mrr = 1'b0;
        chk("rstw_valids", {mrv, mwv, busy}, 0);
        chk("rstw_readies", {rrdy, wrdy}, 0);
        chk("rstw_grant_id", gid, 0);
        chk("rstw_data", rdata, 0);
        chk("rstw_addr", mra, 0);
        rv = 4'b1010;
        step();
        chk("rstw_regrant", {mrv, gid, rrdy}, {1'b1, 2'd1, 4'b0});
        rv = '0;

        // Early valid drop during the read wait.
        do_reset();
        rv[3] = 1'b1; raddr[3*AB +: AB] = 8'h66;
        step();
        rv[3] = 1'b0;
        step();
        chk("drop_no_abort", {mrv, busy}, 2'b11);
        mrr = 1'b1; mrd = 16'hC0DE;
        step();
        mrr = 1'b0;
        chk("drop_pulse", rrdy, 4'b1000);
        chk("drop_data", rdata[3*DB +: DB], 16'hC0DE);
        step();
        chk("drop_pulse_end", {rrdy, busy}, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            model_step();
            step();
            chk_model();
            drive_random();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
